// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and compare flags.
// Executes one operation at a time on two unsigned WIDTH-bit operands.
// Single-cycle ops finish at the accept edge. MUL is an iterative shift-add
// that takes WIDTH+1 edges. ACC keeps a running 2*WIDTH-bit sum.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   op, bit1, bit2       operation code and unsigned operands A and B
//   out_valid/out_ready  result handshake; the result is held until taken
//   result               2*WIDTH-bit zero-extended result
//   equal/greater/lesser A ==, >, < B for the accepted operands
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   bit1,
    input  logic [WIDTH-1:0]   bit2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               equal,
    output logic               greater,
    output logic               lesser
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_ACC = 3'b111;

    // Keeps the difference to WIDTH+1 bits so bit WIDTH carries the borrow.
    localparam logic [RW-1:0] SUB_MASK = {{(WIDTH - 1){1'b0}}, {(WIDTH + 1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              accept_s;
    logic [RW-1:0]     a_ext_s;
    logic [RW-1:0]     b_ext_s;
    logic [RW-1:0]     alu_s;
    logic [RW-1:0]     acc_r;
    logic [RW-1:0]     prod_r;
    logic [RW-1:0]     mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [CW-1:0]     cnt_r;

    assign accept_s = in_valid && in_ready;

    // Zero-extend operands to result width so all arithmetic is done at 2*WIDTH bits.
    always_comb begin
        a_ext_s = {{WIDTH{1'b0}}, bit1};
        b_ext_s = {{WIDTH{1'b0}}, bit2};
    end

    // Single-cycle datapath; ACC yields the post-add accumulator value.
    always_comb begin
        alu_s = '0;
        case (op)
            OP_ADD:  alu_s = a_ext_s + b_ext_s;
            OP_SUB:  alu_s = (a_ext_s - b_ext_s) & SUB_MASK;
            OP_CMP:  alu_s = '0;
            OP_AND:  alu_s = a_ext_s & b_ext_s;
            OP_OR:   alu_s = a_ext_s | b_ext_s;
            OP_XOR:  alu_s = a_ext_s ^ b_ext_s;
            OP_ACC:  alu_s = acc_r + a_ext_s;
            default: alu_s = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (op == OP_MUL) begin
                        state_s = ST_MUL;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            // cnt_r == 0 marks the extra cycle that loads the finished product.
            ST_MUL: begin
                if (cnt_r == '0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from state.
    always_comb begin
        in_ready = (state_r == ST_IDLE);
    end

    // out_valid is registered so it follows the DONE state without a decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_s == ST_DONE);
        end
    end

    // Operand latch, result/flag registers, accumulator and shift-add multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result   <= '0;
            equal    <= 1'b0;
            greater  <= 1'b0;
            lesser   <= 1'b0;
            acc_r    <= '0;
            prod_r   <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
        end else if (accept_s) begin
            equal   <= (bit1 == bit2);
            greater <= (bit1 > bit2);
            lesser  <= (bit1 < bit2);
            if (op == OP_MUL) begin
                cnt_r    <= CW'(WIDTH);
                prod_r   <= '0;
                mcand_r  <= a_ext_s;
                mplier_r <= bit2;
            end else begin
                result <= alu_s;
            end
            if (op == OP_ACC) begin
                acc_r <= alu_s;
            end
        end else if (state_r == ST_MUL) begin
            if (cnt_r == '0) begin
                result <= prod_r;
            end else begin
                if (mplier_r[0]) begin
                    prod_r <= prod_r + mcand_r;
                end
                mcand_r  <= mcand_r << 1;
                mplier_r <= mplier_r >> 1;
                cnt_r    <= cnt_r - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed WIDTH=4 cases plus random sweeps
// on a WIDTH=4 and a WIDTH=8 instance, against an arithmetic reference model.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic       iv4, ir4, ov4, or4, eq4, gt4, lt4;
    logic [2:0] op4;
    logic [3:0] a4, b4;
    logic [7:0] res4;

    logic        iv8, ir8, ov8, or8, eq8, gt8, lt8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;

    int checks = 0;
    int failures = 0;
    logic [63:0] acc_m [2];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4),
        .bit1(a4), .bit2(b4), .out_valid(ov4), .out_ready(or4),
        .result(res4), .equal(eq4), .greater(gt4), .lesser(lt4)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .bit1(a8), .bit2(b8), .out_valid(ov8), .out_ready(or8),
        .result(res8), .equal(eq8), .greater(gt8), .lesser(lt8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_res(input bit sel);
        return sel ? 64'(res8) : 64'(res4);
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? ov8 : ov4;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? ir8 : ir4;
    endfunction

    function automatic logic [2:0] get_flags(input bit sel);
        return sel ? {eq8, gt8, lt8} : {eq4, gt4, lt4};
    endfunction

    task automatic drive(input bit sel, input logic iv, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        if (sel) begin
            iv8 = iv; op8 = op; a8 = a; b8 = b;
        end else begin
            iv4 = iv; op4 = op; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    task automatic set_oready(input bit sel, input logic v);
        if (sel) or8 = v;
        else     or4 = v;
    endtask

    // One full transaction: accept, wait for the result, optionally hold
    // backpressure for 'hold' cycles with a stray request, then take it.
    task automatic txn(input bit sel, input logic [2:0] op, input logic [7:0] a_in,
                       input logic [7:0] b_in, input int hold, input string tag);
        int          w;
        int          lat;
        int          exp_lat;
        logic [63:0] a, b, e, m1;
        w  = sel ? 8 : 4;
        a  = sel ? 64'(a_in) : 64'(a_in & 8'h0f);
        b  = sel ? 64'(b_in) : 64'(b_in & 8'h0f);
        m1 = 64'd1 << (w + 1);
        case (op)
            3'd0: e = a + b;
            3'd1: e = (a + m1 - b) % m1;
            3'd2: e = 64'd0;
            3'd3: e = a & b;
            3'd4: e = a | b;
            3'd5: e = a ^ b;
            3'd6: e = a * b;
            default: begin
                acc_m[sel] = (acc_m[sel] + a) % (64'd1 << (2 * w));
                e = acc_m[sel];
            end
        endcase
        exp_lat = (op == 3'd6) ? w + 1 : 0;

        @(negedge clk);
        chk($sformatf("%s.ready_before", tag), 64'(get_ready(sel)), 64'd1);
        drive(sel, 1'b1, op, a_in, b_in);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 3'd0, 8'd0, 8'd0);
        lat = 0;
        while (!get_valid(sel) && lat < 40) begin
            chk($sformatf("%s.ready_busy", tag), 64'(get_ready(sel)), 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
        chk($sformatf("%s.ready_done", tag), 64'(get_ready(sel)), 64'd0);
        chk($sformatf("%s.result", tag), get_res(sel), e);
        chk($sformatf("%s.flags", tag), 64'(get_flags(sel)),
            64'({a == b, a > b, a < b}));

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive(sel, 1'b1, 3'd7, 8'hff, 8'h00);
            @(posedge clk);
            #1;
            chk($sformatf("%s.hold_res", tag), get_res(sel), e);
            chk($sformatf("%s.hold_valid", tag), 64'(get_valid(sel)), 64'd1);
            chk($sformatf("%s.hold_ready", tag), 64'(get_ready(sel)), 64'd0);
        end
        drive(sel, 1'b0, 3'd0, 8'd0, 8'd0);

        @(negedge clk);
        set_oready(sel, 1'b1);
        @(posedge clk);
        #1;
        chk($sformatf("%s.valid_after", tag), 64'(get_valid(sel)), 64'd0);
        chk($sformatf("%s.ready_after", tag), 64'(get_ready(sel)), 64'd1);
        @(negedge clk);
        set_oready(sel, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        drive(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        or4 = 1'b0;
        or8 = 1'b0;
        acc_m[0] = 64'd0;
        acc_m[1] = 64'd0;

        // Reset state.
        #12;
        chk("rst.valid4", 64'(ov4), 64'd0);
        chk("rst.res4", 64'(res4), 64'd0);
        chk("rst.flags4", 64'({eq4, gt4, lt4}), 64'd0);
        chk("rst.ready4", 64'(ir4), 64'd1);
        chk("rst.valid8", 64'(ov8), 64'd0);
        chk("rst.ready8", 64'(ir8), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed WIDTH=4 cases.
        txn(1'b0, 3'd0, 8'b0110, 8'b1100, 0, "add");
        txn(1'b0, 3'd1, 8'b1010, 8'b0010, 0, "sub");
        txn(1'b0, 3'd1, 8'b0110, 8'b1100, 0, "sub_borrow");
        txn(1'b0, 3'd2, 8'b1011, 8'b1111, 0, "cmp_lt");
        txn(1'b0, 3'd2, 8'b1111, 8'b1111, 0, "cmp_eq");
        txn(1'b0, 3'd6, 8'b1111, 8'b1111, 0, "mul_ff");
        txn(1'b0, 3'd6, 8'b0000, 8'b1010, 0, "mul_zero");
        txn(1'b0, 3'd3, 8'b1111, 8'b0000, 0, "and");
        txn(1'b0, 3'd4, 8'b1111, 8'b0000, 0, "or");
        txn(1'b0, 3'd5, 8'b1111, 8'b0000, 0, "xor");
        txn(1'b0, 3'd7, 8'd15, 8'd0, 0, "acc1");
        txn(1'b0, 3'd7, 8'd15, 8'd3, 0, "acc2");
        txn(1'b0, 3'd7, 8'd3, 8'd3, 0, "acc3");
        txn(1'b0, 3'd0, 8'b1111, 8'b1111, 0, "add_max");
        txn(1'b0, 3'd1, 8'd0, 8'd1, 0, "sub_0m1");
        txn(1'b0, 3'd0, 8'b0011, 8'b0101, 10, "backpressure");

        // Reset in the middle of a MUL, with an ACC offered during reset.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd6, 8'hf, 8'hf);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b1, 3'd7, 8'd5, 8'd0);
        #1;
        chk("midmul.valid", 64'(ov4), 64'd0);
        chk("midmul.res", 64'(res4), 64'd0);
        chk("midmul.ready", 64'(ir4), 64'd1);
        chk("midmul.flags", 64'({eq4, gt4, lt4}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        acc_m[0] = 64'd0;
        acc_m[1] = 64'd0;
        txn(1'b0, 3'd7, 8'd1, 8'd0, 0, "acc_after_rst");

        // WIDTH=8 boundaries.
        txn(1'b1, 3'd0, 8'hff, 8'hff, 0, "w8_add_max");
        txn(1'b1, 3'd1, 8'h00, 8'h01, 0, "w8_sub_0m1");
        txn(1'b1, 3'd6, 8'h00, 8'hab, 0, "w8_mul_zero");
        txn(1'b1, 3'd6, 8'hff, 8'hff, 0, "w8_mul_max");
        txn(1'b1, 3'd7, 8'hff, 8'h10, 0, "w8_acc");

        // Random sweeps.
        for (int i = 0; i < 40; i++) begin
            txn(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), $urandom_range(0, 2),
                $sformatf("w8_rand%0d", i));
        end
        for (int i = 0; i < 15; i++) begin
            txn(1'b0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 15)),
                8'($urandom_range(0, 15)), $urandom_range(0, 2),
                $sformatf("w4_rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
